rvfi_cover_monitor: RTL
=======================

Name: rvfi_cover_monitor

Overview:
- Synthesizable RVFI retirement-stream monitor for the minrv32 formal and simulation benches.
- Counts retirement event classes across NRET retire slots into saturating counters, and flags per-class coverage goals against a threshold.
- Checks rvfi_order continuity.
- Instantiated beside the core, fed by the core's RVFI outputs; its goal and error outputs drive cover properties and assertions.

Parameters:
- NRET, 1, number of retire slots per cycle (1..4).
- CNT_W, 8, width of each event counter in bits.
- THRESH, 2, counter value at or above which a class goal is met (1..2^CNT_W-1).
- COMPRESSED_ISA, 0, when 0, class 3 counts every valid retirement (long or short); when 1, class 3 counts only insn[1:0]!=3.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- clear  in  1  synchronous clear of counters and order_err.
- rvfi_valid  in  NRET  per-slot retire valid.
- rvfi_order  in  64*NRET  per-slot retire index.
- rvfi_insn  in  32*NRET  per-slot instruction word.
- rvfi_trap  in  NRET  per-slot trap flag.
- rvfi_pc_rdata  in  32*NRET  per-slot pc of instruction.
- rvfi_pc_wdata  in  32*NRET  per-slot next pc.
- rvfi_mem_rmask  in  4*NRET  per-slot read byte mask.
- rvfi_mem_wmask  in  4*NRET  per-slot write byte mask.
- cnt  out  6*CNT_W  packed counters; class k occupies bits [k*CNT_W +: CNT_W].
- goal  out  6  goal[k] = cnt_k >= THRESH.
- all_goal  out  1  AND of goal[5:0].
- order_err  out  1  sticky order/slot-packing violation.
- retired  out  64  expected next rvfi_order, i.e. total retirements seen.

Behaviour:
- Reset (resetn=0 at posedge): all counters 0, order_err 0, retired 0. Consequently goal=0 and all_goal=0 (THRESH>=1).
- Only valid slots (rvfi_valid[s]=1) contribute.
- Per-slot event classes:
  - 0 dmem read: rmask!=0.
  - 1 dmem write: wmask!=0.
  - 2 long insn: insn[1:0]==3.
  - 3 compressed insn: per COMPRESSED_ISA.
  - 4 trap: rvfi_trap=1.
  - 5 discontinuity: pc_wdata != pc_rdata + (insn[1:0]==3 ? 4 : 2), using 32-bit modulo add.
- Per cycle, inc_k = number of valid slots hitting class k (0..NRET).
- Counter update: cnt_k <= min(cnt_k + inc_k, 2^CNT_W-1).
  - Computed with CNT_W+3 bits; saturates, never wraps.
- Latency: events visible on cnt one cycle after the retiring edge. goal and all_goal are combinational from the registered counters, so same cycle as cnt.
- Order check, with E = retired and V = number of valid slots:
  - Slot packing: valid slots must be contiguous from slot 0. Any rvfi_valid[s]=1 with rvfi_valid[s-1]=0 sets order_err.
  - Sequence: each valid slot s must have rvfi_order = E+s, otherwise order_err is set.
  - Advance: retired <= E+V every cycle, even after an error, so the check resynchronises only relative to the expected count.
- order_err is sticky until clear or reset.
- clear=1: counters and order_err go to 0 at the next edge.
  - Events in the clear cycle are dropped; an order violation in the clear cycle is also discarded.
  - retired still advances by V.
- resetn=0 takes priority over clear and over all events.
- Reset mid-stream: the core restarts rvfi_order at 0, consistent with retired=0.
- No valid slots: counters and retired hold.

Test Plan:
- NRET=1, CNT_W=8, THRESH=2: retire LW (0x0000a083, rmask=0xF, pc 0x0→0x4) twice → cnt0=2, cnt2=2, cnt3=2, goal=0b001101, all_goal=0, retired=2, order_err=0.
- Saturation, CNT_W=3: 9 consecutive SW retirements (wmask=0x3) → cnt1 sequence 1..7 then holds 7, no wrap.
- Order gap: orders 0,1,3 → order_err=1 one cycle after order 3 and stays 1, retired=3; then clear=1 → order_err=0, counters 0.
- NRET=2: slot0 LW order 0 and slot1 SW order 1 in one cycle → cnt0=1, cnt1=1, cnt2=2, retired=2. Next cycle valid=0b10 → order_err=1.
- Discontinuity/trap: JAL pc 0x100→0x200 with trap=1 → cnt4=1, cnt5=1. Sequential pc 0x200→0x204 → cnt5 stays 1.
- Clear versus event in the same cycle: a valid LW with clear=1 → cnt0=0, retired incremented by 1.

Source files
------------

// File: rtl/rvfi_cover_monitor_if.sv
// RVFI retirement-stream bundle, NRET slots wide; the core side drives it,
// the coverage monitor observes it.
interface rvfi_cover_monitor_if #(
  parameter int unsigned NRET = 1
) ();
  logic [NRET-1:0]    rvfi_valid;
  logic [64*NRET-1:0] rvfi_order;
  logic [32*NRET-1:0] rvfi_insn;
  logic [NRET-1:0]    rvfi_trap;
  logic [32*NRET-1:0] rvfi_pc_rdata;
  logic [32*NRET-1:0] rvfi_pc_wdata;
  logic [4*NRET-1:0]  rvfi_mem_rmask;
  logic [4*NRET-1:0]  rvfi_mem_wmask;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_rmask, rvfi_mem_wmask
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_rmask, rvfi_mem_wmask
  );
endinterface

// File: rtl/rvfi_cover_monitor.sv
// RVFI retirement monitor: saturating per-class event counters with coverage
// goals, plus a sticky rvfi_order continuity / slot-packing check.
module rvfi_cover_monitor #(
  parameter int unsigned NRET           = 1,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned THRESH         = 2,
  parameter int unsigned COMPRESSED_ISA = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  rvfi_cover_monitor_if.slave  rvfi,
  output logic [6*CNT_W-1:0]   cnt,
  output logic [5:0]           goal,
  output logic                 all_goal,
  output logic                 order_err,
  output logic [63:0]          retired
);

  localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic             order_err_q, order_err_d;
  logic [63:0]      retired_q, retired_d;

  logic [2:0]       inc [6];
  logic [2:0]       nvalid;
  logic             viol;
  logic [5:0]       cls;
  logic             long_insn;
  logic [31:0]      pc_seq;
  logic [CNT_W+2:0] sum;

  // Only the length field of the instruction word is needed here.
  logic             unused_insn;
  assign unused_insn = ^rvfi.rvfi_insn;

  always_comb begin
    for (int unsigned k = 0; k < 6; k++) begin
      inc[k] = '0;
    end
    nvalid    = '0;
    viol      = 1'b0;
    cls       = '0;
    long_insn = 1'b0;
    pc_seq    = '0;

    for (int unsigned s = 0; s < NRET; s++) begin
      if (rvfi.rvfi_valid[s]) begin
        long_insn = (rvfi.rvfi_insn[s*32 +: 2] == 2'b11);
        pc_seq    = rvfi.rvfi_pc_rdata[s*32 +: 32] + (long_insn ? 32'd4 : 32'd2);
        cls[0]    = |rvfi.rvfi_mem_rmask[s*4 +: 4];
        cls[1]    = |rvfi.rvfi_mem_wmask[s*4 +: 4];
        cls[2]    = long_insn;
        cls[3]    = (COMPRESSED_ISA != 0) ? !long_insn : 1'b1;
        cls[4]    = rvfi.rvfi_trap[s];
        cls[5]    = (rvfi.rvfi_pc_wdata[s*32 +: 32] != pc_seq);
        for (int unsigned k = 0; k < 6; k++) begin
          inc[k] = inc[k] + {2'b00, cls[k]};
        end
        nvalid = nvalid + 3'd1;
        if (rvfi.rvfi_order[s*64 +: 64] != retired_q + 64'(s)) begin
          viol = 1'b1;
        end
      end
    end

    // A valid slot above an empty one breaks contiguous packing from slot 0.
    for (int unsigned s = 1; s < NRET; s++) begin
      if (rvfi.rvfi_valid[s] && !rvfi.rvfi_valid[s-1]) begin
        viol = 1'b1;
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      sum = {3'b000, cnt_q[k]} + {{CNT_W{1'b0}}, inc[k]};
      if (clear) begin
        cnt_d[k] = '0;
      end else if (sum > CNT_MAX) begin
        cnt_d[k] = '1;
      end else begin
        cnt_d[k] = sum[CNT_W-1:0];
      end
    end
    order_err_d = clear ? 1'b0 : (order_err_q | viol);
    retired_d   = retired_q + {61'd0, nvalid};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < 6; k++) begin
        cnt_q[k] <= '0;
      end
      order_err_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < 6; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      order_err_q <= order_err_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      cnt[k*CNT_W +: CNT_W] = cnt_q[k];
      goal[k]               = (cnt_q[k] >= CNT_W'(THRESH));
    end
    all_goal  = &goal;
    order_err = order_err_q;
    retired   = retired_q;
  end

endmodule
